// File: rtl/wbus_arbiter.sv
// wbus_arbiter: round-robin W-bus arbiter with registered bus-hold value, one-cycle turnaround
// and an optional hold-time limit that forces release to prevent starvation.
module wbus_arbiter #(
  parameter int N_REQ    = 4,
  parameter int WIDTH    = 16,
  parameter int MAX_HOLD = 8
) (
  input  logic                   CLK,
  input  logic                   CLR,
  input  logic [N_REQ-1:0]       req,
  input  logic [N_REQ*WIDTH-1:0] data_in,
  output logic [N_REQ-1:0]       grant,
  output logic [2:0]             grant_id,
  output logic [WIDTH-1:0]       bus_out,
  output logic                   bus_valid,
  output logic                   busy,
  output logic                   timeout
);
  localparam int HW = MAX_HOLD > 1 ? $clog2(MAX_HOLD) : 1;
  typedef enum logic [1:0] {IDLE, OWN, TURN} state_t;
  state_t state, state_nx;
  logic [2:0] ptr, win;
  logic [HW-1:0] hold_cnt;
  logic [2*N_REQ-1:0] req2;
  logic [WIDTH-1:0] own_data;
  logic any, own_req, at_limit, release_own;
  assign req2 = {req, req};
  assign any = |req;
  // grant is one-hot on the owner while in OWN, so this picks req[owner]
  assign own_req = |(req & grant);
  assign at_limit = (MAX_HOLD != 0) && (32'(hold_cnt) == 32'(MAX_HOLD - 1));
  assign release_own = (state == OWN) && (!own_req || at_limit);
  assign busy = state != IDLE;
  // doubled request vector lets the search from ptr wrap without modulo indexing
  always_comb begin
    win = '0;
    for (int i = N_REQ - 1; i >= 0; i--)
      if (req2[int'(ptr) + i]) win = 3'((int'(ptr) + i) % N_REQ);
  end
  always_comb begin
    own_data = '0;
    for (int i = 0; i < N_REQ; i++)
      if (grant[i]) own_data = data_in[i*WIDTH +: WIDTH];
  end
  always_comb begin
    state_nx = state;
    state_nx = state == OWN ? (release_own ? TURN : OWN) : (any ? OWN : IDLE);
  end
  always_ff @(posedge CLK or posedge CLR)
    if (CLR) state <= IDLE;
    else state <= state_nx;
  always_ff @(posedge CLK or posedge CLR)
    if (CLR) begin
      grant     <= '0;
      grant_id  <= '0;
      bus_out   <= '0;
      bus_valid <= 1'b0;
      timeout   <= 1'b0;
      ptr       <= '0;
      hold_cnt  <= '0;
    end else begin
      timeout <= 1'b0;
      if (state != OWN) begin
        if (any) begin
          grant    <= N_REQ'(1) << win;
          grant_id <= win;
          hold_cnt <= '0;
        end
      end else if (release_own) begin
        grant     <= '0;
        bus_valid <= 1'b0;
        ptr       <= grant_id == 3'(N_REQ - 1) ? 3'd0 : grant_id + 3'd1;
        timeout   <= own_req;
      end else begin
        bus_out   <= own_data;
        bus_valid <= 1'b1;
        hold_cnt  <= hold_cnt + 1'b1;
      end
    end
endmodule

// File: tb/tb_wbus_arbiter.sv
// tb_wbus_arbiter: three arbiters (hold limits 2, 8, unlimited) on shared stimulus, checked
// against a per-instance ownership model, a round-robin vector table and directed corner cases.
module tb_wbus_arbiter;
  logic CLK = 1'b0;
  logic CLR = 1'b1;
  logic [3:0] req = '0;
  logic [63:0] data_in = '0;
  logic [3:0] g [3];
  logic [2:0] gid [3];
  logic [15:0] bo [3];
  logic bv [3], bz [3], to [3];
  int tests = 0, fails = 0;
  int mh [3] = '{2, 8, 0};
  int own [3], held [3], mptr [3], mid [3];
  bit turn [3], mvalid [3], mto [3];
  logic [15:0] mbus [3];

  always #5 CLK = ~CLK;

  wbus_arbiter #(.N_REQ(4), .WIDTH(16), .MAX_HOLD(2)) u2 (.CLK(CLK), .CLR(CLR), .req(req),
    .data_in(data_in), .grant(g[0]), .grant_id(gid[0]), .bus_out(bo[0]), .bus_valid(bv[0]),
    .busy(bz[0]), .timeout(to[0]));
  wbus_arbiter #(.N_REQ(4), .WIDTH(16), .MAX_HOLD(8)) u8 (.CLK(CLK), .CLR(CLR), .req(req),
    .data_in(data_in), .grant(g[1]), .grant_id(gid[1]), .bus_out(bo[1]), .bus_valid(bv[1]),
    .busy(bz[1]), .timeout(to[1]));
  wbus_arbiter #(.N_REQ(4), .WIDTH(16), .MAX_HOLD(0)) u0 (.CLK(CLK), .CLR(CLR), .req(req),
    .data_in(data_in), .grant(g[2]), .grant_id(gid[2]), .bus_out(bo[2]), .bus_valid(bv[2]),
    .busy(bz[2]), .timeout(to[2]));

  typedef struct packed {
    logic [3:0]  g;
    logic [2:0]  id;
    logic        to;
    logic        v;
    logic [15:0] bus;
    logic        busy;
  } rr_t;
  rr_t rr [13];

  task automatic chk(string nm, logic [63:0] a, logic [63:0] e);
    tests++;
    if (a !== e) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, a, e);
    end
  endtask

  task automatic mreset();
    for (int k = 0; k < 3; k++) begin
      own[k] = -1; held[k] = 0; mptr[k] = 0; mid[k] = 0;
      turn[k] = 0; mvalid[k] = 0; mto[k] = 0; mbus[k] = '0;
    end
  endtask

  // one clock edge of ownership semantics for instance k, from the pre-edge inputs
  task automatic step(int k);
    int o;
    mto[k] = 0;
    if (own[k] >= 0) begin
      o = own[k];
      if (!req[o] || (mh[k] != 0 && held[k] == mh[k] - 1)) begin
        mto[k] = req[o];
        mvalid[k] = 0;
        mptr[k] = (o + 1) % 4;
        own[k] = -1;
        turn[k] = 1;
      end else begin
        mbus[k] = data_in[o*16 +: 16];
        mvalid[k] = 1;
        held[k]++;
      end
    end else begin
      turn[k] = 0;
      for (int s = 0; s < 4; s++)
        if (own[k] < 0 && req[(mptr[k] + s) % 4]) begin
          own[k] = (mptr[k] + s) % 4;
          mid[k] = own[k];
          held[k] = 0;
        end
    end
  endtask

  function automatic logic [25:0] mexp(int k);
    logic [3:0] eg;
    eg = own[k] >= 0 ? 4'(1 << own[k]) : 4'b0;
    return {eg, 3'(mid[k]), mbus[k], mvalid[k], own[k] >= 0 || turn[k], mto[k]};
  endfunction

  function automatic logic [25:0] act(int k);
    return {g[k], gid[k], bo[k], bv[k], bz[k], to[k]};
  endfunction

  task automatic cyc();
    @(posedge CLK);
    for (int k = 0; k < 3; k++) step(k);
    @(negedge CLK);
    for (int k = 0; k < 3; k++) chk($sformatf("model[%0d]", k), 64'(act(k)), 64'(mexp(k)));
  endtask

  task automatic do_reset();
    CLR = 1'b1;
    @(negedge CLK);
    mreset();
    for (int k = 0; k < 3; k++) chk($sformatf("reset[%0d]", k), 64'(act(k)), 64'(0));
    CLR = 1'b0;
  endtask

  initial begin
    int gc, tc, n;
    rr[0]  = '{4'b0001, 3'd0, 1'b0, 1'b0, 16'h0000, 1'b1};
    rr[1]  = '{4'b0001, 3'd0, 1'b0, 1'b1, 16'h1000, 1'b1};
    rr[2]  = '{4'b0000, 3'd0, 1'b1, 1'b0, 16'h1000, 1'b1};
    rr[3]  = '{4'b0010, 3'd1, 1'b0, 1'b0, 16'h1000, 1'b1};
    rr[4]  = '{4'b0010, 3'd1, 1'b0, 1'b1, 16'h1001, 1'b1};
    rr[5]  = '{4'b0000, 3'd1, 1'b1, 1'b0, 16'h1001, 1'b1};
    rr[6]  = '{4'b0100, 3'd2, 1'b0, 1'b0, 16'h1001, 1'b1};
    rr[7]  = '{4'b0100, 3'd2, 1'b0, 1'b1, 16'h1002, 1'b1};
    rr[8]  = '{4'b0000, 3'd2, 1'b1, 1'b0, 16'h1002, 1'b1};
    rr[9]  = '{4'b1000, 3'd3, 1'b0, 1'b0, 16'h1002, 1'b1};
    rr[10] = '{4'b1000, 3'd3, 1'b0, 1'b1, 16'h1003, 1'b1};
    rr[11] = '{4'b0000, 3'd3, 1'b1, 1'b0, 16'h1003, 1'b1};
    rr[12] = '{4'b0001, 3'd0, 1'b0, 1'b0, 16'h1003, 1'b1};
    mreset();
    do_reset();
    // single requester, voluntary release, bus holds last value
    data_in[16 +: 16] = 16'h00A5;
    req = 4'b0010;
    cyc(); chk("single_grant", 64'(g[1]), 64'(4'b0010));
    cyc(); chk("single_bus", 64'({bv[1], bo[1]}), 64'({1'b1, 16'h00A5}));
    cyc(); req = 4'b0000;
    cyc(); chk("single_turn", 64'({g[1], bz[1]}), 64'({4'b0000, 1'b1}));
    cyc(); chk("single_idle", 64'({bz[1], bo[1]}), 64'({1'b0, 16'h00A5}));
    // round robin with hold limit 2
    do_reset();
    data_in = {16'h1003, 16'h1002, 16'h1001, 16'h1000};
    req = 4'b1111;
    for (int i = 0; i < 13; i++) begin
      cyc();
      chk($sformatf("rr[%0d]", i), 64'({g[0], gid[0], to[0], bv[0], bo[0], bz[0]}), 64'(rr[i]));
    end
    // forced release with hold limit 8, competitor arrives at cycle 3
    do_reset();
    req = 4'b0001;
    gc = 0; tc = 0;
    for (int c = 1; c <= 20; c++) begin
      if (c == 3) req[2] = 1'b1;
      cyc();
      if (c <= 10 && g[1][0]) gc++;
      if (c <= 10 && to[1]) tc++;
      if (c == 10) chk("forced_next", 64'(g[1]), 64'(4'b0100));
    end
    chk("forced_hold", 64'(gc), 64'(8));
    chk("forced_pulses", 64'(tc), 64'(1));
    // voluntary drop coinciding with the hold limit
    req = 4'b0000;
    do_reset();
    req = 4'b0010;
    for (int c = 0; c < 8; c++) cyc();
    req = 4'b0000;
    cyc();
    chk("same_edge", 64'({g[1], to[1], bz[1]}), 64'({4'b0000, 1'b0, 1'b1}));
    // asynchronous reset in the middle of a grant
    do_reset();
    req = 4'b0100;
    cyc(); cyc();
    chk("pre_reset", 64'({g[1], bv[1]}), 64'({4'b0100, 1'b1}));
    #2 CLR = 1'b1;
    #1 chk("async_reset", 64'({g[1], bv[1], bo[1], bz[1]}), 64'(0));
    mreset();
    @(negedge CLK);
    CLR = 1'b0;
    req = 4'b0110;
    cyc(); chk("post_reset_grant", 64'(g[1]), 64'(4'b0010));
    // unlimited hold
    req = 4'b0000;
    do_reset();
    req = 4'b1000;
    cyc();
    req = 4'b1111;
    n = 0;
    for (int c = 0; c < 50; c++) begin
      cyc();
      if (g[2] == 4'b1000 && !to[2]) n++;
    end
    chk("unlimited_hold", 64'(n), 64'(50));
    // random sticky requests against the model
    req = 4'b0000;
    do_reset();
    for (int c = 0; c < 600; c++) begin
      for (int b = 0; b < 4; b++) if ($urandom_range(5) == 0) req[b] = ~req[b];
      data_in = {$urandom, $urandom};
      cyc();
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/wbus_arbiter.md
# wbus_arbiter

Round-robin arbiter and bus-hold register for the SAP-II W-bus. It grants exclusive bus ownership to one of N requesters at a time, such as the program counter, the MDR and DMA-style I/O ports. It registers the granted requester's data onto the bus and holds the last value when the bus is idle. A mandatory turnaround cycle and a hold-time limit prevent bus contention and starvation. It sits between the datapath sources and the shared W-bus consumers (IR, MAR, output ports).

## Interface
Parameters:
- N_REQ, 4, number of requesters (2..8)
- WIDTH, 16, bus width in bits
- MAX_HOLD, 8, maximum cycles a grant is held before forced release; 0 = unlimited

Ports:
- CLK  input  1  system clock, rising-edge
- CLR  input  1  asynchronous reset, active-high
- req  input  N_REQ  request per requester; level, held while ownership is wanted
- data_in  input  N_REQ*WIDTH  requester data, slice i = data_in[i*WIDTH +: WIDTH]
- grant  output  N_REQ  one-hot ownership, registered
- grant_id  output  3  encoded index of the current or last owner
- bus_out  output  WIDTH  registered W-bus value; holds its last value when no owner
- bus_valid  output  1  bus_out carries current owner data
- busy  output  1  state != IDLE
- timeout  output  1  one-cycle pulse on a forced release

## Operation
- States: IDLE, OWN, TURN.
- Arbitration happens at the exit edge of IDLE or TURN when any req is high.
  - Search starts at ptr and goes upward, wrapping modulo N_REQ. The first set bit wins.
  - On a win: grant <= onehot(winner), grant_id <= winner, hold_cnt <= 0, state <= OWN.
  - If no req is high, IDLE stays IDLE and TURN goes to IDLE.
- OWN, normal edge (no release): bus_out <= data_in[owner], bus_valid <= 1, hold_cnt <= hold_cnt+1.
- Release condition in OWN: req[owner]==0, or (MAX_HOLD!=0 and hold_cnt==MAX_HOLD-1).
- Release edge:
  - grant <= 0, bus_valid <= 0, bus_out unchanged, ptr <= (owner+1) mod N_REQ, state <= TURN.
  - timeout <= 1 only if the release was forced by the hold limit while req[owner] was still 1.
  - If both conditions are true on the same edge, the release counts as voluntary (no timeout).
- TURN lasts exactly one cycle. No grant is asserted during TURN.
- After a forced release the former owner competes normally. Because ptr has moved past it, any other pending requester wins first.
- grant is always one-hot or zero. grant_id keeps the last owner after release.
- Requests that arrive while another requester owns the bus wait. They are never lost, since req is a level.
- Reset values (asynchronous, immediate, including mid-grant): state IDLE, grant 0, grant_id 0, bus_out 0, bus_valid 0, busy 0, timeout 0, ptr 0, hold_cnt 0.

## Timing
- Latency from request to grant: req sampled high at edge k in IDLE gives grant high after edge k.
- Data timing: first bus_valid and bus_out = data_in[owner] after edge k+1. Data seen by consumers is one cycle behind data_in.
- With MAX_HOLD=M and req held continuously, grant is high for exactly M cycles and bus_valid for M-1 cycles.
- Minimum gap between consecutive grants is one TURN cycle: release at edge r, TURN, new grant at edge r+1.
- timeout is high for exactly the one cycle following the forced release edge.
- busy goes high with grant and falls at the TURN→IDLE edge.

## Test plan
- Reset / single requester:
  - Stimulus: CLR pulse, then req=4'b0010 with data_in[1]=16'h00A5, dropped after 3 cycles.
  - Response: all outputs 0 during reset. grant=4'b0010 one cycle after req. bus_out=16'h00A5 with bus_valid the next cycle. After req drops: grant 0, one TURN cycle, then IDLE, and bus_out stays 16'h00A5.
- Round-robin fairness:
  - Stimulus: req=4'b1111 held, MAX_HOLD=2.
  - Response: grant sequence 0001, 0010, 0100, 1000, 0001, each grant high 2 cycles and separated by one TURN cycle, with a timeout pulse after each.
- Forced release:
  - Stimulus: MAX_HOLD=8, req[0] held for 20 cycles, req[2] raised at cycle 3.
  - Response: grant[0] held 8 cycles, timeout pulses once, TURN, then grant[2].
- Voluntary and limit on the same edge:
  - Stimulus: req[owner] drops on the cycle where hold_cnt==MAX_HOLD-1.
  - Response: release occurs and timeout stays 0.
- Reset mid-grant:
  - Stimulus: CLR asserted asynchronously while grant=4'b0100 and bus_valid=1.
  - Response: grant, bus_valid and bus_out go to 0 immediately, without waiting for a clock edge. After CLR falls with req=4'b0110, the first grant goes to requester 1 (ptr=0).
- MAX_HOLD=0:
  - Stimulus: req[3] held for 50 cycles with other requests pending.
  - Response: grant[3] held for all 50 cycles, timeout never asserts.
